// File: rtl/axi_lite_pkg.sv
`default_nettype none
// ============================================================================
// Module : axi_lite_pkg
// Brief  : Shared AXI4-Lite constants: response codes and B-channel states.
// Rev    : 1.0 - initial release
// ============================================================================
package axi_lite_pkg;

    localparam int RESP_W = 2;

    localparam logic [RESP_W-1:0] OKAY   = 2'b00;
    localparam logic [RESP_W-1:0] EXOKAY = 2'b01;
    localparam logic [RESP_W-1:0] SLVERR = 2'b10;
    localparam logic [RESP_W-1:0] DECERR = 2'b11;

    typedef logic [1:0] b_state_t;

    localparam b_state_t B_IDLE = 2'b00;
    localparam b_state_t B_WAIT = 2'b01;
    localparam b_state_t B_CAPT = 2'b10;

endpackage : axi_lite_pkg
`default_nettype wire

// File: rtl/write_response_ms.sv
`default_nettype none
// ============================================================================
// Module : write_response_ms
// Brief  : AXI4-Lite B-channel capture, master side; registers BRESP on handshake.
// Rev    : 1.0 - initial release
// ============================================================================
module write_response_ms
    import axi_lite_pkg::*;
#(
    parameter int RESP_W = axi_lite_pkg::RESP_W
) (
    input  logic              ACLK,
    input  logic              ARESETn,
    input  logic              BREADY,
    input  logic              BVALID,
    input  logic [RESP_W-1:0] i_BRESP,
    output logic [RESP_W-1:0] o_BRESP
);

    b_state_t          state_q;
    b_state_t          state_d;
    logic [RESP_W-1:0] bresp_q;
    logic [RESP_W-1:0] bresp_d;
    logic              w_hs;

    assign w_hs = BVALID && BREADY;

    always_comb begin
        state_d = B_IDLE;
        case (state_q)
            B_IDLE: begin
                if (w_hs)        state_d = B_CAPT;
                else if (BVALID) state_d = B_WAIT;
                else             state_d = B_IDLE;
            end
            B_WAIT: begin
                if (w_hs)         state_d = B_CAPT;
                else if (!BVALID) state_d = B_IDLE;
                else              state_d = B_WAIT;
            end
            B_CAPT: begin
                if (w_hs)        state_d = B_CAPT;
                else if (BVALID) state_d = B_WAIT;
                else             state_d = B_IDLE;
            end
            default: state_d = B_IDLE;
        endcase
    end

    // Capture follows the handshake directly so the unused encoding never drops a response
    always_comb begin
        bresp_d = bresp_q;
        if (w_hs) bresp_d = i_BRESP;
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q <= B_IDLE;
            bresp_q <= OKAY;
        end else begin
            state_q <= state_d;
            bresp_q <= bresp_d;
        end
    end

    assign o_BRESP = bresp_q;

endmodule : write_response_ms
`default_nettype wire

// File: tb/tb_write_response_ms.sv
`default_nettype none
// ============================================================================
// Module : tb_write_response_ms
// Brief  : Directed, table-driven self-checking bench for write_response_ms.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_write_response_ms;
    import axi_lite_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       bready;
    logic       bvalid;
    logic [1:0] bresp_in;
    logic [1:0] bresp_out;

    int n_checks = 0;
    int n_errors = 0;

    write_response_ms #(.RESP_W(2)) dut (
        .ACLK    (clk),
        .ARESETn (rst_n),
        .BREADY  (bready),
        .BVALID  (bvalid),
        .i_BRESP (bresp_in),
        .o_BRESP (bresp_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic       bvalid;
        logic       bready;
        logic [1:0] bresp;
        logic [1:0] exp_bresp;
        logic [1:0] exp_state;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic v, input logic b,
                       input logic [1:0] d, input logic [1:0] e, input logic [1:0] s);
        vec_t t;
        t.rst_n = r; t.bvalid = v; t.bready = b;
        t.bresp = d; t.exp_bresp = e; t.exp_state = s;
        vecs.push_back(t);
    endtask

    task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic v, input logic b, input logic [1:0] d);
        rst_n = r; bvalid = v; bready = b; bresp_in = d;
    endtask

    initial begin
        drive(1'b0, 1'b0, 1'b0, 2'b00);

        //   rst  v  r  bresp  exp   state
        add(1'b0, 0, 0, 2'b11, 2'b00, B_IDLE);
        add(1'b1, 0, 0, 2'b11, 2'b00, B_IDLE);
        add(1'b1, 1, 0, 2'b11, 2'b00, B_WAIT);   // stall x3
        add(1'b1, 1, 0, 2'b11, 2'b00, B_WAIT);
        add(1'b1, 1, 0, 2'b11, 2'b00, B_WAIT);
        add(1'b1, 1, 1, 2'b11, 2'b11, B_CAPT);   // handshake, then hold both high
        add(1'b1, 1, 1, 2'b11, 2'b11, B_CAPT);
        add(1'b1, 1, 1, 2'b00, 2'b00, B_CAPT);   // back-to-back
        add(1'b1, 1, 1, 2'b01, 2'b01, B_CAPT);
        add(1'b1, 1, 1, 2'b10, 2'b10, B_CAPT);
        add(1'b1, 0, 0, 2'b01, 2'b10, B_IDLE);   // hold
        add(1'b1, 0, 0, 2'b11, 2'b10, B_IDLE);
        add(1'b1, 0, 1, 2'b00, 2'b10, B_IDLE);
        add(1'b1, 1, 0, 2'b01, 2'b10, B_WAIT);
        add(1'b1, 0, 0, 2'b11, 2'b10, B_IDLE);
        add(1'b1, 1, 1, 2'b01, 2'b01, B_CAPT);
        add(1'b1, 1, 0, 2'b10, 2'b01, B_WAIT);
        add(1'b1, 1, 1, 2'b10, 2'b10, B_CAPT);
        add(1'b1, 0, 1, 2'b11, 2'b10, B_IDLE);

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].rst_n, vecs[i].bvalid, vecs[i].bready, vecs[i].bresp);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_bresp", i), bresp_out, vecs[i].exp_bresp);
            check($sformatf("vec%0d_state", i), dut.state_q, vecs[i].exp_state);
        end

        // Asynchronous reset from 11 with no clock edge in between
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b1, 2'b11);
        @(posedge clk);
        #1;
        check("async_pre", bresp_out, 2'b11);
        drive(1'b1, 1'b0, 1'b0, 2'b11);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_bresp", bresp_out, 2'b00);
        check("async_state", dut.state_q, B_IDLE);

        // Reset during an ongoing handshake, then recover
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b1, 2'b10);
        @(posedge clk);
        #1;
        check("midop_pre", bresp_out, 2'b10);
        drive(1'b1, 1'b1, 1'b1, 2'b11);
        #2;
        rst_n = 1'b0;
        #1;
        check("midop_bresp", bresp_out, 2'b00);
        @(posedge clk);
        #1;
        check("midop_held", bresp_out, 2'b00);
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b1, 2'b01);
        @(posedge clk);
        #1;
        check("midop_recover", bresp_out, 2'b01);
        check("midop_state", dut.state_q, B_CAPT);

        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 2'b00);
        @(posedge clk);
        #1;
        check("final_hold", bresp_out, 2'b01);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_write_response_ms
`default_nettype wire
